// File: rtl/sample_adc_capture_if.sv
// ---------------------------------------------------------------------------
// sample_adc_capture_if
//
// This interface carries the AXI-Stream output of the ADC capture block.
//
// Signals
//   tdata   DATA_W  captured beat (the timestamp header, or sample data)
//   tvalid  1       a beat is presented
//   tready  1       the downstream sink accepts the presented beat
//   tlast   1       this beat is the final beat of a capture window
//
// Modports
//   master  the capture block. It drives tdata, tvalid and tlast.
//   slave   the downstream DMA/PS path. It drives tready.
// ---------------------------------------------------------------------------
interface sample_adc_capture_if #(
  parameter int DATA_W = 128
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sample_adc_capture.sv
// ---------------------------------------------------------------------------
// sample_adc_capture
//
// Purpose
//   This block receives 128-bit JESD rx beats. A trigger pulse starts a
//   capture window. The block skips a programmable number of valid beats, and
//   then captures a programmable number of beats. The captured window streams
//   out through an output FIFO as an AXI-Stream master. Every started window
//   ends with exactly one tlast, even when beats must be dropped.
//
// Optional feature (macro CAPTURE_TIMESTAMP_EN)
//   When this macro is defined, a free-running 32-bit cycle counter runs. Each
//   accepted trigger pushes one header beat {zeros, ts_at_trigger}, with
//   tlast=0, ahead of the window data.
//
// Ports
//   rx_core_clk    clock for all logic
//   rx_core_reset  synchronous, active-high reset
//   rx_tdata       rx sample beat
//   rx_tvalid      qualifier for rx_tdata
//   trig_i         1-cycle trigger pulse; honoured only in IDLE
//   arm_i          triggers are accepted only while this level is high
//   delay_i        number of valid beats to skip after the trigger
//   len_i          number of beats to capture; 0 means the trigger is ignored
//   m_axis         AXI-Stream master (see sample_adc_capture_if)
//   busy_o         high while a window is in progress
//   overflow_o     sticky flag: at least one beat was dropped
//   clr_ovf_i      clears overflow_o; a set in the same cycle wins
//   capture_cnt_o  number of windows started since reset (wraps)
// ---------------------------------------------------------------------------
module sample_adc_capture #(
  parameter int DATA_W     = 128,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                 rx_core_clk,
  input  logic                 rx_core_reset,
  input  logic [DATA_W-1:0]    rx_tdata,
  input  logic                 rx_tvalid,
  input  logic                 trig_i,
  input  logic                 arm_i,
  input  logic [CNT_W-1:0]     delay_i,
  input  logic [CNT_W-1:0]     len_i,
  sample_adc_capture_if.master m_axis,
  output logic                 busy_o,
  output logic                 overflow_o,
  input  logic                 clr_ovf_i,
  output logic [31:0]          capture_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  // One FIFO slot is always held back for the tlast beat of the open window.
  // The effective occupancy is therefore the stored count plus one. A non-last
  // beat is admitted only while stored + 1 < FIFO_DEPTH - 1.
  localparam logic [OCC_W-1:0] ADMIT_LIMIT = OCC_W'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_CAPTURE, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    delay_cnt_q, delay_cnt_d;
  logic [CNT_W-1:0]    len_cnt_q, len_cnt_d;
  logic [31:0]         capture_cnt_q, capture_cnt_d;
  logic                overflow_q, overflow_d;

  // This is a one-deep push stage between the FSM and the FIFO. It gives the
  // two-cycle rx-to-m_axis latency. The FIFO admission check is made here,
  // against the occupancy at the moment of the write.
  logic                push_q, push_d;
  logic                push_last_q, push_last_d;
  logic [DATA_W-1:0]   push_data_q, push_data_d;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [DATA_W:0]     mem_q [FIFO_DEPTH];

  logic                wr_en;
  logic                rd_en;
  logic                fifo_drained;
  logic [DATA_W:0]     rd_word;

`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0]         ts_q, ts_d;
`endif

  assign rd_en   = m_axis.tready && (occ_q != '0);
  // The last beat bypasses the occupancy limit. This works because of the
  // slot that was held back for it.
  assign wr_en   = push_q && (push_last_q || (occ_q < ADMIT_LIMIT));
  // The window is complete once no push is in flight and the FIFO is empty,
  // or becomes empty with this pop.
  assign fifo_drained = !push_q &&
                        ((occ_q == '0) || ((occ_q == OCC_W'(1)) && rd_en));

  always_comb begin
    state_d       = state_q;
    delay_cnt_d   = delay_cnt_q;
    len_cnt_d     = len_cnt_q;
    capture_cnt_d = capture_cnt_q;
    push_d        = 1'b0;
    push_last_d   = 1'b0;
    push_data_d   = rx_tdata;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    overflow_d    = overflow_q;
`ifdef CAPTURE_TIMESTAMP_EN
    ts_d          = ts_q + 32'd1;
`endif

    // FIFO bookkeeping
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    // Overflow is sticky. A drop in the same cycle takes priority over a clear.
    if (push_q && !wr_en) overflow_d = 1'b1;
    else if (clr_ovf_i)   overflow_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm_i && trig_i && (len_i != '0)) begin
          delay_cnt_d   = delay_i;
          len_cnt_d     = len_i;
          capture_cnt_d = capture_cnt_q + 32'd1;
`ifdef CAPTURE_TIMESTAMP_EN
          // The FIFO is empty in IDLE, so the header always fits.
          push_d        = 1'b1;
          push_data_d   = DATA_W'(ts_q);
`endif
          state_d       = (delay_i != '0) ? S_DELAY : S_CAPTURE;
        end
      end
      S_DELAY: begin
        if (rx_tvalid) begin
          // The beat that takes the count to zero is itself skipped.
          delay_cnt_d = delay_cnt_q - CNT_W'(1);
          if (delay_cnt_q == CNT_W'(1)) state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (rx_tvalid) begin
          push_d      = 1'b1;
          push_last_d = (len_cnt_q == CNT_W'(1));
          len_cnt_d   = len_cnt_q - CNT_W'(1);
          if (len_cnt_q == CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_drained) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_core_clk) begin
    if (rx_core_reset) begin
      state_q       <= S_IDLE;
      delay_cnt_q   <= '0;
      len_cnt_q     <= '0;
      capture_cnt_q <= '0;
      overflow_q    <= 1'b0;
      push_q        <= 1'b0;
      push_last_q   <= 1'b0;
      push_data_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
`ifdef CAPTURE_TIMESTAMP_EN
      ts_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      delay_cnt_q   <= delay_cnt_d;
      len_cnt_q     <= len_cnt_d;
      capture_cnt_q <= capture_cnt_d;
      overflow_q    <= overflow_d;
      push_q        <= push_d;
      push_last_q   <= push_last_d;
      push_data_q   <= push_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
`ifdef CAPTURE_TIMESTAMP_EN
      ts_q          <= ts_d;
`endif
    end
  end

  // The storage array has no reset. Occupancy alone decides what is valid.
  always_ff @(posedge rx_core_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {push_last_q, push_data_q};
  end

  // First-word-fall-through read. The head entry is forced to zero while the
  // FIFO is empty, so the outputs idle at 0.
  assign rd_word       = mem_q[rd_ptr_q];
  assign m_axis.tvalid = (occ_q != '0);
  assign m_axis.tdata  = (occ_q != '0) ? rd_word[DATA_W-1:0] : '0;
  assign m_axis.tlast  = (occ_q != '0) ? rd_word[DATA_W] : 1'b0;

  assign busy_o        = (state_q != S_IDLE);
  assign overflow_o    = overflow_q;
  assign capture_cnt_o = capture_cnt_q;

endmodule

// File: tb/tb_sample_adc_capture.sv
// ---------------------------------------------------------------------------
// tb_sample_adc_capture
//
// Self-checking bench for sample_adc_capture.
//
// The stimulus issues triggers and random rx beats. For each window, a
// window-level model decides which beats must come out: skip `delay` valid
// beats, take `len`, and mark the last one. Under a stalled sink, only the
// first beats that fit are kept, plus the last beat.
//
// Each expected beat is pushed onto a queue. A negedge monitor pops and
// compares whenever the DUT transfers a beat.
// ---------------------------------------------------------------------------
module tb_sample_adc_capture;
  localparam int DATA_W     = 128;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 16;
`ifdef CAPTURE_TIMESTAMP_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] rx_tdata;
  logic              rx_tvalid;
  logic              trig_i;
  logic              arm_i;
  logic [CNT_W-1:0]  delay_i;
  logic [CNT_W-1:0]  len_i;
  logic              busy_o;
  logic              overflow_o;
  logic              clr_ovf_i;
  logic [31:0]       capture_cnt_o;

  sample_adc_capture_if #(.DATA_W(DATA_W)) m_axis_if ();

  sample_adc_capture #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .rx_core_clk   (clk),
    .rx_core_reset (rst),
    .rx_tdata      (rx_tdata),
    .rx_tvalid     (rx_tvalid),
    .trig_i        (trig_i),
    .arm_i         (arm_i),
    .delay_i       (delay_i),
    .len_i         (len_i),
    .m_axis        (m_axis_if.master),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o),
    .clr_ovf_i     (clr_ovf_i),
    .capture_cnt_o (capture_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W:0] sb[$];
  int   exp_cap  = 0;
  logic exp_ovf  = 1'b0;
  int   ready_mode = 0;   // 0: stall, 1: always ready, 2: random
  logic [31:0] cyc;

  always @(posedge clk) begin
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;
  end

  task automatic check(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Downstream ready generator
  initial begin
    m_axis_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_axis_if.tready = 1'b0;
        1:       m_axis_if.tready = 1'b1;
        default: m_axis_if.tready = ($urandom_range(99) < 70);
      endcase
    end
  end

  // Monitor: one line per transferred beat; also checks hold stability
  logic            stall_prev = 1'b0;
  logic [DATA_W:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold_stable", {m_axis_if.tvalid, m_axis_if.tlast, m_axis_if.tdata},
              {1'b1, held});
      if (m_axis_if.tvalid && m_axis_if.tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got data=%h last=%0d expected no beat",
                   m_axis_if.tdata, m_axis_if.tlast);
        end else begin
          logic [DATA_W:0] e;
          e = sb.pop_front();
          $display("beat data=%h last=%0d", m_axis_if.tdata, m_axis_if.tlast);
          check("beat", {m_axis_if.tlast, m_axis_if.tdata}, e);
        end
      end
      stall_prev = m_axis_if.tvalid && !m_axis_if.tready;
      held       = {m_axis_if.tlast, m_axis_if.tdata};
    end
  end

  // Issue one accepted trigger in the current cycle
  task automatic fire(input int dly, input int len);
    arm_i     = 1'b1;
    trig_i    = 1'b1;
    delay_i   = CNT_W'(dly);
    len_i     = CNT_W'(len);
    rx_tvalid = 1'b0;
    exp_cap++;
`ifdef CAPTURE_TIMESTAMP_EN
    sb.push_back({1'b0, 96'h0, cyc});
`endif
    step();
    trig_i = 1'b0;
    check("busy_after_trig", busy_o, 1);
  endtask

  // Feed a window: toggle=1 gives rx_tvalid 1010..., otherwise random with
  // probability vprob%. keep_limit bounds the stored non-last beats.
  task automatic run_window(input int dly, input int len, input int vprob,
                            input bit toggle, input bit spurious,
                            input int keep_limit);
    int seen = 0;
    int kept = 0;
    int c    = 0;
    fire(dly, len);
    while (seen < dly + len) begin
      rx_tvalid = toggle ? ((c % 2) == 0) : ($urandom_range(99) < vprob);
      rx_tdata  = rand_beat();
      if (spurious && ($urandom_range(5) == 0)) begin
        trig_i  = 1'b1;
        arm_i   = $urandom_range(1);
        delay_i = CNT_W'($urandom_range(3));
        len_i   = CNT_W'($urandom_range(8));
      end else begin
        trig_i  = 1'b0;
      end
      if (rx_tvalid) begin
        if (seen >= dly) begin
          bit last;
          last = (seen - dly) == (len - 1);
          if (last || kept < keep_limit) begin
            sb.push_back({last, rx_tdata});
            if (!last) kept++;
          end
        end
        seen++;
      end
      c++;
      step();
    end
    trig_i = 1'b0;
    arm_i  = 1'b1;
    // Beats after the window must be ignored
    repeat (3) begin
      rx_tvalid = $urandom_range(1);
      rx_tdata  = rand_beat();
      step();
    end
    rx_tvalid = 1'b0;
  endtask

  task automatic finish_window();
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    check("drain_empty", sb.size(), 0);
    repeat (3) step();
    check("busy_idle", busy_o, 0);
    check("capture_cnt", capture_cnt_o, exp_cap);
    check("overflow", overflow_o, exp_ovf);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_tdata = '0; rx_tvalid = 1'b0; trig_i = 1'b0; arm_i = 1'b0;
    delay_i = '0; len_i = '0; clr_ovf_i = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    step();
    check("reset_out", {m_axis_if.tvalid, m_axis_if.tlast, m_axis_if.tdata}, 0);
    check("reset_busy", busy_o, 0);
    check("reset_ovf", overflow_o, 0);
    check("reset_cnt", capture_cnt_o, 0);

    // T1: delay 0, len 4, ramp, latency N+2
    ready_mode = 1;
    step();
    fire(0, 4);
    for (int i = 0; i < 4; i++) begin
      rx_tvalid = 1'b1;
      rx_tdata  = DATA_W'(i + 1);
      sb.push_back({i == 3, DATA_W'(i + 1)});
      step();
`ifndef CAPTURE_TIMESTAMP_EN
      if (i == 0) check("lat_n1_tvalid", m_axis_if.tvalid, 0);
      if (i == 1) check("lat_n2_beat", {m_axis_if.tvalid, m_axis_if.tdata},
                        {1'b1, DATA_W'(1)});
`endif
    end
    rx_tvalid = 1'b0;
    finish_window();

    // T2: delay 3, len 2, tvalid toggling
    run_window(3, 2, 0, 1'b1, 1'b0, 1000);
    finish_window();

    // T4: ignored triggers in IDLE (arm low, len zero)
    arm_i = 1'b0; trig_i = 1'b1; len_i = 16'd5; delay_i = 16'd0;
    step();
    arm_i = 1'b1; len_i = 16'd0;
    step();
    trig_i = 1'b0;
    repeat (4) begin rx_tvalid = 1'b1; rx_tdata = rand_beat(); step(); end
    rx_tvalid = 1'b0;
    check("ign_busy", busy_o, 0);
    repeat (4) step();
    check("ign_cnt", capture_cnt_o, exp_cap);

    // T3: stalled sink, len 40 -> DEPTH-2 stored beats plus the last beat
    ready_mode = 0;
    step(); step();
    run_window(0, 40, 100, 1'b0, 1'b1, FIFO_DEPTH - 2 - HDR);
    repeat (2) step();
    check("ovf_set", overflow_o, 1);
    exp_ovf    = 1'b1;
    ready_mode = 1;
    finish_window();
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    exp_ovf   = 1'b0;
    check("ovf_clr", overflow_o, 0);

    // T5: reset mid-capture
    ready_mode = 0;
    step(); step();
    fire(0, 20);
    repeat (5) begin rx_tvalid = 1'b1; rx_tdata = rand_beat(); step(); end
    rx_tvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    exp_cap = 0;
    check("rst_mid_tvalid", m_axis_if.tvalid, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_ovf", overflow_o, 0);
    check("rst_mid_cnt", capture_cnt_o, 0);
    ready_mode = 1;
    step();
    run_window(1, 3, 100, 1'b0, 1'b0, 1000);
    finish_window();

    // Randomised windows with random sink backpressure and spurious triggers
    ready_mode = 2;
    for (int w = 0; w < 12; w++) begin
      run_window($urandom_range(5), $urandom_range(12, 1),
                 $urandom_range(100, 30), 1'b0, 1'b1, 1000);
      finish_window();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
